coproc_lanes: RTL

Parametrised successor to the UART frame coprocessor. Accepts fixed-width frames split into LANES independent lanes and applies a per-frame mode: pass, delayed history, lanewise sum/diff/max against a selectable past frame, or multi-frame accumulate. Sits between the UART frame deserialiser and serialiser. Adds valid/ready backpressure, a HIST_DEPTH frame history and an accumulate state machine.

---
 rtl/coproc_lanes.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/coproc_lanes.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | coproc_lanes: lanewise frame coprocessor with history and ACCUM FSM  |
// | Optional macro COPROC_SAT_EN: saturating SUM/ACCUM, DIFF clamps at 0 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module coproc_lanes #(
  parameter int LANES      = 18,
  parameter int LANE_W     = 8,
  parameter int HIST_DEPTH = 4,
  parameter int CNT_W      = 8,
  localparam int TAP_W     = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1,
  localparam int W         = LANES * LANE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [W-1:0]     dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  input  logic [2:0]       mode,
  input  logic [TAP_W-1:0] tap,
  input  logic [CNT_W-1:0] accum_len,
  input  logic             clear,
  output logic             busy,
  output logic [CNT_W-1:0] frame_count
);

  localparam logic             C_IDLE    = 1'b0;
  localparam logic             C_ACC     = 1'b1;
  localparam logic [TAP_W:0]   C_TAP_MAX = (TAP_W + 1)'(HIST_DEPTH - 1);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

  logic             state_q, state_d;
  logic [W-1:0]     dout_q, dout_d, acc_q, acc_d;
  logic             dout_valid_q, dout_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d, frame_count_q, frame_count_d;
  logic [W-1:0]     hist_q [HIST_DEPTH];
  logic [W-1:0]     hist_d [HIST_DEPTH];

  logic [W-1:0]     w_h, w_sum, w_diff, w_max, w_acc_sum, w_op, w_result;
  logic             w_accept, w_emit;
  logic [CNT_W-1:0] w_cnt_inc;

  assign din_ready   = !clear && (!dout_valid_q || dout_ready);
  assign w_accept    = din_valid && din_ready;
  assign w_cnt_inc   = cnt_q + C_ONE;
  // Out-of-range taps fall back to the oldest retained frame.
  assign w_h         = ({1'b0, tap} > C_TAP_MAX) ? hist_q[HIST_DEPTH-1] : hist_q[tap];

  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign frame_count = frame_count_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LANE_W-1:0] w_a, w_hl, w_c;
    assign w_a  = din[i*LANE_W +: LANE_W];
    assign w_hl = w_h[i*LANE_W +: LANE_W];
    assign w_c  = acc_q[i*LANE_W +: LANE_W];
    assign w_max[i*LANE_W +: LANE_W] = (w_a > w_hl) ? w_a : w_hl;
`ifdef COPROC_SAT_EN
    logic [LANE_W:0] w_sum_x, w_acc_x;
    assign w_sum_x = {1'b0, w_a} + {1'b0, w_hl};
    assign w_acc_x = {1'b0, w_c} + {1'b0, w_a};
    assign w_sum[i*LANE_W +: LANE_W]     = w_sum_x[LANE_W] ? {LANE_W{1'b1}} : w_sum_x[LANE_W-1:0];
    assign w_diff[i*LANE_W +: LANE_W]    = (w_a < w_hl) ? {LANE_W{1'b0}} : w_a - w_hl;
    assign w_acc_sum[i*LANE_W +: LANE_W] = w_acc_x[LANE_W] ? {LANE_W{1'b1}} : w_acc_x[LANE_W-1:0];
`else
    assign w_sum[i*LANE_W +: LANE_W]     = w_a + w_hl;
    assign w_diff[i*LANE_W +: LANE_W]    = w_a - w_hl;
    assign w_acc_sum[i*LANE_W +: LANE_W] = w_c + w_a;
`endif
  end

  always_comb begin
    case (mode)
      3'd1:    w_op = w_h;
      3'd2:    w_op = w_sum;
      3'd3:    w_op = w_diff;
      3'd5:    w_op = w_max;
      default: w_op = din;
    endcase
  end

  // State register plus all datapath flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= C_IDLE;
      dout_q        <= '0;
      dout_valid_q  <= 1'b0;
      acc_q         <= '0;
      cnt_q         <= '0;
      len_q         <= '0;
      frame_count_q <= '0;
      for (int k = 0; k < HIST_DEPTH; k++) hist_q[k] <= '0;
    end else begin
      state_q       <= state_d;
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      len_q         <= len_d;
      frame_count_q <= frame_count_d;
      for (int k = 0; k < HIST_DEPTH; k++) hist_q[k] <= hist_d[k];
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = C_IDLE;
    end else if (w_accept) begin
      case (state_q)
        C_IDLE:  if (mode == 3'd4 && accum_len > C_ONE) state_d = C_ACC;
        default: if (w_cnt_inc == len_q) state_d = C_IDLE;
      endcase
    end
  end

  assign busy = (state_q == C_ACC);

  always_comb begin
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    frame_count_d = frame_count_q;
    hist_d        = hist_q;
    w_emit        = 1'b0;
    w_result      = w_op;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
      for (int k = 0; k < HIST_DEPTH; k++) hist_d[k] = '0;
    end else if (w_accept) begin
      frame_count_d = frame_count_q + C_ONE;
      hist_d[0]     = din;
      for (int k = 1; k < HIST_DEPTH; k++) hist_d[k] = hist_q[k-1];
      if (state_q == C_ACC) begin
        acc_d = w_acc_sum;
        if (w_cnt_inc == len_q) begin
          w_emit   = 1'b1;
          w_result = w_acc_sum;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end else if (mode == 3'd4) begin
        acc_d = din;
        cnt_d = C_ONE;
        len_d = accum_len;
        if (accum_len <= C_ONE) begin
          w_emit   = 1'b1;
          w_result = din;
        end
      end else begin
        w_emit = 1'b1;
      end
    end

    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    if (w_accept && w_emit) begin
      dout_d       = w_result;
      dout_valid_d = 1'b1;
    end else if (dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

endmodule
`default_nettype wire
